map_reader: RTL

MAP_READER -- requirements
Module: map_reader

---
 rtl/map_reader_if.sv | 29 ++
 rtl/map_reader.sv | 81 ++++++++
 2 files changed

// File: rtl/map_reader_if.sv
// Bundles the snapshot request, row-beat stream and status of map_reader.
// master = the reader that drives the stream; slave = the requester/consumer.
interface map_reader_if #(
   parameter int ROWS = 16,
   parameter int COLS = 16
);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CNT_W = $clog2(ROWS * COLS + 1);

   logic [ROWS*COLS-1:0] map_in;
   logic                 start;
   logic                 busy;
   logic                 out_valid;
   logic                 out_ready;
   logic [ROW_W-1:0]     out_row;
   logic [COLS-1:0]      out_data;
   logic                 done;
   logic [CNT_W-1:0]     live_count;

   modport master (
      input  map_in, start, out_ready,
      output busy, out_valid, out_row, out_data, done, live_count
   );

   modport slave (
      output map_in, start, out_ready,
      input  busy, out_valid, out_row, out_data, done, live_count
   );
endinterface

// File: rtl/map_reader.sv
// Snapshots the life map on start and streams it one row per beat; first beat the cycle after start.
// A beat holds (row, data, live_count stable) while out_ready is low; one-cycle done pulse after the last row.
module map_reader #(
   parameter int ROWS = 16,
   parameter int COLS = 16
) (
   input  logic         clk,
   input  logic         rst,
   map_reader_if.master bus
);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CNT_W = $clog2(ROWS * COLS + 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

   state_e                      state_q, state_d;
   logic [ROWS-1:0][COLS-1:0]   snap_q, snap_d;
   logic [ROW_W-1:0]            row_q, row_d;
   logic [CNT_W-1:0]            live_q, live_d;
   logic [COLS-1:0]             row_dat;
   logic [CNT_W-1:0]            row_pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         snap_q  <= '0;
         row_q   <= '0;
         live_q  <= '0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         row_q   <= row_d;
         live_q  <= live_d;
      end
   end

   always_comb begin
      row_dat = snap_q[row_q];
      row_pop = '0;
      for (int c = 0; c < COLS; c++) begin
         row_pop = row_pop + CNT_W'(row_dat[c]);
      end
   end

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      row_d   = row_q;
      live_d  = live_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               snap_d  = bus.map_in;
               row_d   = '0;
               live_d  = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (bus.out_ready) begin
               live_d = live_q + row_pop;
               // Row index parks on the last row; DONE/IDLE never present it as valid.
               if (row_q == ROW_W'(ROWS - 1)) begin
                  state_d = DONE;
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.out_valid  = (state_q == SCAN);
   assign bus.done       = (state_q == DONE);
   assign bus.out_row    = row_q;
   assign bus.out_data   = row_dat;
   assign bus.live_count = live_q;
endmodule
